delay_line_ctrl: RTL and testbench

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

---
 rtl/audio_fx_pkg.sv | 23 ++
 rtl/rd_latency_pipe.sv | 38 +++
 rtl/delay_line_ctrl.sv | 166 ++++++++++++++++
 tb/tb_delay_line_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effects blocks: default widths and the
// delay-line controller state encoding.
package audio_fx_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned RAM_DEPTH  = 1024;
    localparam int unsigned RD_LATENCY = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_TRIM  = 3'd3,
        ST_FLUSH = 3'd4
    } dl_state_e;

    // States in which incoming samples are written into the delay FIFO.
    function automatic logic is_stream_state(input dl_state_e s);
        return (s == ST_FILL) || (s == ST_RUN) || (s == ST_TRIM);
    endfunction

endpackage

// File: rtl/rd_latency_pipe.sv
// Tracks each accepted sample through the FIFO read latency and presents the
// delayed sample (FIFO data or zero) with a one-cycle valid strobe.
module rd_latency_pipe #(
    parameter int unsigned data_width = 16,
    parameter int unsigned rd_latency = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         issue_i,
    input  logic                         use_fifo_i,
    input  logic signed [data_width-1:0] fifo_data_i,
    output logic signed [data_width-1:0] sample_o,
    output logic                         valid_o
);

    logic [rd_latency-1:0] valid_q;
    logic [rd_latency-1:0] sel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            sel_q   <= '0;
        end else begin
            valid_q[0] <= issue_i;
            sel_q[0]   <= issue_i && use_fifo_i;
            for (int unsigned i = 1; i < rd_latency; i++) begin
                valid_q[i] <= valid_q[i-1];
                sel_q[i]   <= sel_q[i-1];
            end
        end
    end

    // FIFO read data is valid exactly in the cycle the tracking bit emerges,
    // so it is passed through here rather than re-registered.
    assign valid_o  = valid_q[rd_latency-1];
    assign sample_o = (valid_o && sel_q[rd_latency-1]) ? fifo_data_i : '0;

endmodule

// File: rtl/delay_line_ctrl.sv
// Delay-line controller: keeps an external FIFO filled to delay_len samples,
// streams delayed samples out, and trims/refills when the delay changes.
module delay_line_ctrl
    import audio_fx_pkg::*;
#(
    parameter int unsigned data_width    = DATA_WIDTH,
    parameter int unsigned address_width = ADDR_WIDTH,
    parameter int unsigned ram_depth     = RAM_DEPTH,
    parameter int unsigned rd_latency    = RD_LATENCY
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [address_width-1:0]        delay_len,
    input  logic                            sample_valid,
    input  logic signed [data_width-1:0]    sample_in,
    output logic                            fifo_wr_en,
    output logic                            fifo_rd_en,
    output logic signed [data_width-1:0]    fifo_data_in,
    input  logic signed [data_width-1:0]    fifo_data_out,
    input  logic [address_width-1:0]        fifo_fill,
    input  logic                            fifo_full,
    input  logic                            fifo_empty,
    output logic signed [data_width-1:0]    sample_out,
    output logic                            sample_out_valid,
    output logic [2:0]                      state,
    output logic                            overflow,
    output logic                            underrun
);

    localparam int unsigned AW1   = address_width + 1;
    localparam int unsigned GAP_W = $clog2(rd_latency + 3);
    localparam logic [AW1-1:0]   DELAY_MAX  = AW1'(ram_depth - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(rd_latency + 1);

    dl_state_e          state_q;
    logic               discard_q;
    logic [GAP_W-1:0]   gap_q;
    logic               overflow_q;
    logic               underrun_q;

    logic [AW1-1:0]     fill_ext;
    logic [AW1-1:0]     fill_p1;
    logic [AW1-1:0]     delay_ext;
    logic               accept;
    logic               need_read;
    logic               wr_en_c;
    logic               rd_req;
    logic               discard_rd;
    logic               flush_rd;

    assign fill_ext = {1'b0, fifo_fill};
    assign fill_p1  = fill_ext + AW1'(1);

    // Out-of-range delay requests are clamped to what the FIFO can hold.
    always_comb begin
        delay_ext = {1'b0, delay_len};
        if (delay_ext > DELAY_MAX) begin
            delay_ext = DELAY_MAX;
        end
        if (delay_ext == '0) begin
            delay_ext = AW1'(1);
        end
    end

    assign accept     = sample_valid && enable && is_stream_state(state_q) && (gap_q == '0);
    assign need_read  = accept && ((state_q == ST_RUN) || (state_q == ST_TRIM));
    assign wr_en_c    = accept && !fifo_full;
    assign rd_req     = need_read && !fifo_empty;
    assign discard_rd = discard_q && !fifo_empty;
    assign flush_rd   = (state_q == ST_FLUSH) && !fifo_empty;

    assign fifo_wr_en   = wr_en_c;
    assign fifo_data_in = wr_en_c ? sample_in : '0;
    assign fifo_rd_en   = rd_req || discard_rd || flush_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            discard_q  <= 1'b0;
            gap_q      <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            discard_q <= 1'b0;
            if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
            if (accept) begin
                gap_q <= GAP_RELOAD;
            end
            if (accept && fifo_full) begin
                overflow_q <= 1'b1;
            end
            if (need_read && fifo_empty) begin
                underrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q    <= ST_FILL;
                        overflow_q <= 1'b0;
                        underrun_q <= 1'b0;
                    end
                end
                ST_FILL, ST_RUN, ST_TRIM: begin
                    if (!enable) begin
                        state_q <= ST_FLUSH;
                    end else if (accept) begin
                        // fifo_fill is the occupancy before this sample's write.
                        case (state_q)
                            ST_FILL: begin
                                if (fill_p1 >= delay_ext) begin
                                    state_q <= ST_RUN;
                                end
                            end
                            ST_RUN: begin
                                if (fill_ext < delay_ext) begin
                                    state_q <= ST_FILL;
                                end else if (fill_ext > delay_ext) begin
                                    state_q <= ST_TRIM;
                                end
                            end
                            default: begin
                                if (fill_ext == delay_ext) begin
                                    state_q <= ST_RUN;
                                end else if (fill_ext < delay_ext) begin
                                    state_q <= ST_FILL;
                                end else begin
                                    discard_q <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state    = state_q;
    assign overflow = overflow_q;
    assign underrun = underrun_q;

    rd_latency_pipe #(
        .data_width (data_width),
        .rd_latency (rd_latency)
    ) u_rd_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .issue_i     (accept),
        .use_fifo_i  (rd_req),
        .fifo_data_i (fifo_data_out),
        .sample_o    (sample_out),
        .valid_o     (sample_out_valid)
    );

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl with a behavioural FIFO (read latency 2).
module tb_delay_line_ctrl;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [9:0]         delay_len;
    logic               sample_valid;
    logic signed [15:0] sample_in;
    logic               fifo_wr_en;
    logic               fifo_rd_en;
    logic signed [15:0] fifo_data_in;
    logic signed [15:0] fifo_data_out;
    logic [9:0]         fifo_fill;
    logic               fifo_full;
    logic               fifo_empty;
    logic signed [15:0] sample_out;
    logic               sample_out_valid;
    logic [2:0]         state;
    logic               overflow;
    logic               underrun;

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;

    logic               force_full = 1'b0;
    logic               force_empty = 1'b0;
    logic signed [15:0] q[$];
    logic signed [15:0] s1_q;
    logic [9:0]         fill_q;

    always #5 clk = ~clk;

    delay_line_ctrl #(
        .data_width    (16),
        .address_width (10),
        .ram_depth     (1024),
        .rd_latency    (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .delay_len        (delay_len),
        .sample_valid     (sample_valid),
        .sample_in        (sample_in),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_rd_en       (fifo_rd_en),
        .fifo_data_in     (fifo_data_in),
        .fifo_data_out    (fifo_data_out),
        .fifo_fill        (fifo_fill),
        .fifo_full        (fifo_full),
        .fifo_empty       (fifo_empty),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .state            (state),
        .overflow         (overflow),
        .underrun         (underrun)
    );

    // FIFO model: read data appears two clock edges after the read strobe.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            s1_q          <= '0;
            fifo_data_out <= '0;
            fill_q        <= '0;
        end else begin
            if (fifo_rd_en && q.size() > 0) begin
                s1_q <= q.pop_front();
            end
            fifo_data_out <= s1_q;
            if (fifo_wr_en) begin
                q.push_back(fifo_data_in);
            end
            fill_q <= 10'(q.size());
        end
    end

    assign fifo_fill  = fill_q;
    assign fifo_empty = (fill_q == 10'd0) || force_empty;
    assign fifo_full  = (fill_q == 10'd1023) || force_full;

    always @(posedge clk) begin
        if (reset_n && fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One sample every 8 cycles; checks strobes in the sample cycle and the
    // delayed output exactly two cycles later. 'early' adds a too-soon pulse.
    task automatic send(input int v, input logic exp_rd, input int exp_out, input logic early);
        @(negedge clk);
        sample_in    = 16'(v);
        sample_valid = 1'b1;
        #1;
        chk("wr_en", fifo_wr_en, 1);
        chk("rd_en", fifo_rd_en, exp_rd);
        chk("data_in", fifo_data_in, v);
        @(negedge clk);
        sample_valid = 1'b0;
        #1;
        chk("valid_early", sample_out_valid, 0);
        @(negedge clk);
        #1;
        chk("valid", sample_out_valid, 1);
        chk("sample_out", sample_out, exp_out);
        if (early) begin
            sample_in    = 16'sd999;
            sample_valid = 1'b1;
            #1;
            chk("spacing_ignored", fifo_wr_en, 0);
            @(negedge clk);
            sample_valid = 1'b0;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int stray;
        reset_n      = 1'b0;
        enable       = 1'b0;
        delay_len    = 10'd4;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_wr", fifo_wr_en, 0);
        chk("rst_rd", fifo_rd_en, 0);
        chk("rst_data_in", fifo_data_in, 0);
        chk("rst_out", sample_out, 0);
        chk("rst_valid", sample_out_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unr", underrun, 0);

        // IDLE ignores sample_valid
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = 16'sd77;
        #1;
        chk("idle_wr", fifo_wr_en, 0);
        @(negedge clk);
        sample_valid = 1'b0;
        #1;
        chk("idle_state", state, 0);
        enable    = 1'b1;
        delay_len = 10'd4;
        @(negedge clk);
        #1;
        chk("fill_state", state, 1);

        // delay 4: four zeros, then the ramp
        send(1, 0, 0, 0);
        send(2, 0, 0, 1);
        send(3, 0, 0, 0);
        send(4, 0, 0, 0);
        chk("run_state", state, 2);
        send(5, 1, 1, 0);
        send(6, 1, 2, 0);
        send(7, 1, 3, 0);
        send(8, 1, 4, 0);

        // grow to 8
        delay_len = 10'd8;
        send(9, 1, 5, 0);
        chk("grow_fill", state, 1);
        send(10, 0, 0, 0);
        send(11, 0, 0, 0);
        send(12, 0, 0, 0);
        send(13, 0, 0, 0);
        send(14, 1, 6, 0);
        chk("grow_run", state, 2);

        // shrink to 5: three discard reads
        delay_len = 10'd5;
        send(15, 1, 7, 0);
        chk("trim_state", state, 3);
        base = rd_cnt;
        send(16, 1, 8, 0);
        send(17, 1, 10, 0);
        send(18, 1, 12, 0);
        chk("trim_reads", rd_cnt - base, 6);
        base = rd_cnt;
        send(19, 1, 14, 0);
        chk("trim_exit_reads", rd_cnt - base, 1);
        chk("trim_run", state, 2);
        send(20, 1, 15, 0);
        chk("trim_unr", underrun, 0);

        // grow 5 -> 9
        delay_len = 10'd9;
        send(21, 1, 16, 0);
        send(22, 0, 0, 0);
        send(23, 0, 0, 0);
        send(24, 0, 0, 0);
        send(25, 0, 0, 0);
        send(26, 1, 17, 0);
        chk("grow9_run", state, 2);

        // forced empty, then forced full
        force_empty = 1'b1;
        send(27, 0, 0, 0);
        force_empty = 1'b0;
        chk("unr_set", underrun, 1);
        chk("unr_ovf_clear", overflow, 0);
        force_full = 1'b1;
        @(negedge clk);
        sample_in    = 16'sd28;
        sample_valid = 1'b1;
        #1;
        chk("ovf_wr", fifo_wr_en, 0);
        chk("ovf_rd", fifo_rd_en, 1);
        @(negedge clk);
        sample_valid = 1'b0;
        force_full   = 1'b0;
        @(negedge clk);
        #1;
        chk("ovf_valid", sample_out_valid, 1);
        chk("ovf_out", sample_out, 18);
        repeat (5) @(negedge clk);
        chk("ovf_set", overflow, 1);
        chk("ovf_trim", state, 3);

        // disable at fill 9: flush everything, flags held
        enable = 1'b0;
        base   = rd_cnt;
        @(negedge clk);
        #1;
        chk("flush_state", state, 4);
        for (int i = 0; i < 60 && state != 3'd0; i++) @(negedge clk);
        #1;
        chk("flush9_idle", state, 0);
        chk("flush9_reads", rd_cnt - base, 9);
        chk("flush9_empty", fifo_empty, 1);
        chk("ovf_held", overflow, 1);
        chk("unr_held", underrun, 1);

        // re-enable clears sticky flags; fill to 6 then flush with one pending
        enable    = 1'b1;
        delay_len = 10'd6;
        @(negedge clk);
        #1;
        chk("reen_state", state, 1);
        chk("reen_ovf", overflow, 0);
        chk("reen_unr", underrun, 0);
        for (int i = 101; i <= 106; i++) send(i, 0, 0, 0);
        chk("f6_run", state, 2);
        send(107, 1, 101, 0);
        @(negedge clk);
        sample_in    = 16'sd108;
        sample_valid = 1'b1;
        #1;
        chk("f6_rd", fifo_rd_en, 1);
        @(negedge clk);
        sample_valid = 1'b0;
        enable       = 1'b0;
        base         = rd_cnt;
        @(negedge clk);
        #1;
        chk("pend_valid", sample_out_valid, 1);
        chk("pend_out", sample_out, 102);
        chk("pend_state", state, 4);
        stray = 0;
        for (int i = 0; i < 60 && state != 3'd0; i++) begin
            @(negedge clk);
            #1;
            if (sample_out_valid) stray++;
        end
        chk("flush6_idle", state, 0);
        chk("flush6_reads", rd_cnt - base, 6);
        chk("flush6_empty", fifo_empty, 1);
        chk("flush6_stray", stray, 0);

        // reset in the middle of a TRIM discard read
        enable    = 1'b1;
        delay_len = 10'd3;
        @(negedge clk);
        send(201, 0, 0, 0);
        send(202, 0, 0, 0);
        send(203, 0, 0, 0);
        chk("d3_run", state, 2);
        delay_len = 10'd2;
        send(204, 1, 201, 0);
        chk("d2_trim", state, 3);
        @(negedge clk);
        sample_in    = 16'sd205;
        sample_valid = 1'b1;
        #1;
        chk("t_rd", fifo_rd_en, 1);
        @(negedge clk);
        sample_valid = 1'b0;
        #1;
        chk("t_discard", fifo_rd_en, 1);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        chk("mrst_state", state, 0);
        chk("mrst_rd", fifo_rd_en, 0);
        chk("mrst_wr", fifo_wr_en, 0);
        chk("mrst_data_in", fifo_data_in, 0);
        chk("mrst_out", sample_out, 0);
        chk("mrst_valid", sample_out_valid, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        stray   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (sample_out_valid) stray++;
        end
        chk("post_rst_state", state, 0);
        chk("post_rst_stray", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
